irq_call_sequencer: RTL and testbench

//  Sits between instruction fetch and the PC block; drives the PC's opcode (resetCode) and value inputs.

---
 rtl/irq_call_sequencer_if.sv | 34 +++
 rtl/irq_call_sequencer.sv | 161 ++++++++++++++++
 tb/tb_irq_call_sequencer.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/irq_call_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : irq_call_sequencer_if
// Purpose  : Fetch-side / PC-side signal bundle of the interrupt CALL sequencer.
// Revision : 1.0  initial release
// ============================================================================
interface irq_call_sequencer_if #(
    parameter int NUM_IRQ      = 4,
    parameter int OPCODE_WIDTH = 4,
    parameter int VALUE_WIDTH  = 8
);
    logic [OPCODE_WIDTH-1:0] fetchOpcode;
    logic [VALUE_WIDTH-1:0]  fetchValue;
    logic [NUM_IRQ-1:0]      irqReq;
    logic                    cfgWrite;
    logic [NUM_IRQ+1:0]      cfgData;
    logic [OPCODE_WIDTH-1:0] pcOpcode;
    logic [VALUE_WIDTH-1:0]  pcValue;
    logic [NUM_IRQ-1:0]      irqAck;
    logic                    inService;
    logic [4:0]              depth;
    logic                    stackFault;

    modport master (
        output fetchOpcode, fetchValue, irqReq, cfgWrite, cfgData,
        input  pcOpcode, pcValue, irqAck, inService, depth, stackFault
    );

    modport slave (
        input  fetchOpcode, fetchValue, irqReq, cfgWrite, cfgData,
        output pcOpcode, pcValue, irqAck, inService, depth, stackFault
    );
endinterface
`default_nettype wire

// File: rtl/irq_call_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : irq_call_sequencer
// Purpose  : Forwards fetched opcodes to the PC, injects CALLs to interrupt
//            vectors and tracks return-stack depth with a sticky fault.
// Revision : 1.0  initial release
// ============================================================================
module irq_call_sequencer #(
    parameter int                      NUM_IRQ       = 4,
    parameter int                      OPCODE_WIDTH  = 4,
    parameter int                      VALUE_WIDTH   = 8,
    parameter int                      STACK_DEPTH   = 16,
    parameter logic [VALUE_WIDTH-1:0]  VECTOR_BASE   = 8'h10,
    parameter logic [VALUE_WIDTH-1:0]  VECTOR_STRIDE = 8'h04,
    parameter logic [OPCODE_WIDTH-1:0] OP_RST        = 4'h1,
    parameter logic [OPCODE_WIDTH-1:0] OP_CALL       = 4'h2,
    parameter logic [OPCODE_WIDTH-1:0] OP_RET        = 4'h3
) (
    input  logic                 clock,
    input  logic                 reset_n,
    irq_call_sequencer_if.slave  bus
);

    localparam logic [4:0] c_stack_full = 5'(STACK_DEPTH);

    typedef enum logic [1:0] {
        S_HOLD  = 2'd0,
        S_RUN   = 2'd1,
        S_FAULT = 2'd2
    } state_t;

    state_t             r_state;
    logic [NUM_IRQ-1:0] r_irq_prev;
    logic [NUM_IRQ-1:0] r_pending;
    logic [NUM_IRQ-1:0] r_mask;
    logic [NUM_IRQ-1:0] r_irq_ack;
    logic               r_gen;
    logic               r_in_service;
    logic               r_stack_fault;
    logic [4:0]         r_depth;
    logic [4:0]         r_entry_depth;

    logic [NUM_IRQ-1:0]     w_rise;
    logic [NUM_IRQ-1:0]     w_qualified;
    logic [NUM_IRQ-1:0]     w_sel_onehot;
    logic [VALUE_WIDTH-1:0] w_vector;
    logic                   w_fetch_ctl;
    logic                   w_take;
    logic                   w_cfg_clear;

    assign w_rise      = bus.irqReq & ~r_irq_prev;
    assign w_qualified = r_pending & r_mask;
    assign w_fetch_ctl = (bus.fetchOpcode == OP_RET) || (bus.fetchOpcode == OP_RST);
    assign w_take      = (r_state == S_RUN) && r_gen && !r_in_service && (|w_qualified)
                         && (r_depth < c_stack_full) && !w_fetch_ctl;
    assign w_cfg_clear = bus.cfgWrite && bus.cfgData[NUM_IRQ+1];

    // Descending scan so the lowest qualified index is the final assignment.
    always_comb begin
        w_sel_onehot = '0;
        w_vector     = VECTOR_BASE;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (w_qualified[i]) begin
                w_sel_onehot    = '0;
                w_sel_onehot[i] = 1'b1;
                w_vector        = VECTOR_BASE + VALUE_WIDTH'(i) * VECTOR_STRIDE;
            end
        end
    end

    always_comb begin
        bus.pcOpcode = OP_RST;
        bus.pcValue  = '0;
        if (r_state == S_RUN) begin
            if (w_take) begin
                bus.pcOpcode = OP_CALL;
                bus.pcValue  = w_vector;
            end else begin
                bus.pcOpcode = bus.fetchOpcode;
                bus.pcValue  = bus.fetchValue;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_HOLD;
            r_irq_prev    <= '0;
            r_pending     <= '0;
            r_mask        <= '0;
            r_irq_ack     <= '0;
            r_gen         <= 1'b0;
            r_in_service  <= 1'b0;
            r_stack_fault <= 1'b0;
            r_depth       <= '0;
            r_entry_depth <= '0;
        end else begin
            r_irq_prev <= bus.irqReq;
            r_irq_ack  <= '0;
            r_pending  <= (r_pending & ~(w_take ? w_sel_onehot : '0)) | w_rise;
            if (bus.cfgWrite) begin
                r_mask <= bus.cfgData[NUM_IRQ-1:0];
                r_gen  <= bus.cfgData[NUM_IRQ];
            end
            // A fault raised below overrides this clear.
            if (w_cfg_clear) begin
                r_stack_fault <= 1'b0;
            end

            case (r_state)
                S_HOLD: begin
                    r_state <= S_RUN;
                end
                S_FAULT: begin
                    r_depth      <= '0;
                    r_in_service <= 1'b0;
                    r_pending    <= '0;
                    r_state      <= S_RUN;
                end
                S_RUN: begin
                    if (w_take) begin
                        r_depth       <= r_depth + 5'd1;
                        r_in_service  <= 1'b1;
                        r_entry_depth <= r_depth;
                        r_irq_ack     <= w_sel_onehot;
                    end else if (bus.fetchOpcode == OP_CALL) begin
                        if (r_depth == c_stack_full) begin
                            r_stack_fault <= 1'b1;
                            r_state       <= S_FAULT;
                        end else begin
                            r_depth <= r_depth + 5'd1;
                        end
                    end else if (bus.fetchOpcode == OP_RET) begin
                        if (r_depth == 5'd0) begin
                            r_stack_fault <= 1'b1;
                            r_state       <= S_FAULT;
                        end else begin
                            r_depth <= r_depth - 5'd1;
                            if (r_in_service && (r_depth == r_entry_depth + 5'd1)) begin
                                r_in_service <= 1'b0;
                            end
                        end
                    end else if (bus.fetchOpcode == OP_RST) begin
                        r_depth      <= '0;
                        r_in_service <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_HOLD;
                end
            endcase
        end
    end

    assign bus.irqAck     = r_irq_ack;
    assign bus.inService  = r_in_service;
    assign bus.depth      = r_depth;
    assign bus.stackFault = r_stack_fault;

endmodule
`default_nettype wire

// File: tb/tb_irq_call_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_irq_call_sequencer
// Purpose  : Directed scenarios plus randomized traffic against a queue-based
//            return-stack model of the interrupt CALL sequencer.
// Revision : 1.0  initial release
// ============================================================================
module tb_irq_call_sequencer;

    localparam int         NUM_IRQ = 4;
    localparam int         SD      = 16;
    localparam logic [3:0] NOP     = 4'h0;
    localparam logic [3:0] RST     = 4'h1;
    localparam logic [3:0] CALL    = 4'h2;
    localparam logic [3:0] RET     = 4'h3;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    irq_call_sequencer_if #(.NUM_IRQ(NUM_IRQ), .OPCODE_WIDTH(4), .VALUE_WIDTH(8)) bus ();

    irq_call_sequencer #(
        .NUM_IRQ(NUM_IRQ), .OPCODE_WIDTH(4), .VALUE_WIDTH(8), .STACK_DEPTH(SD),
        .VECTOR_BASE(8'h10), .VECTOR_STRIDE(8'h04),
        .OP_RST(RST), .OP_CALL(CALL), .OP_RET(RET)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Model: the return stack is a queue whose entries remember whether they
    // were pushed by an interrupt entry; popping that entry ends the ISR.
    int       m_mode;      // 0: restart cycle, 1: running, 2: fault cycle
    bit       m_stack[$];
    bit [3:0] m_pending, m_mask, m_prev, m_ack;
    bit       m_gen, m_isr, m_fault;

    function automatic int lowest(input bit [3:0] v);
        for (int i = 0; i < NUM_IRQ; i++) if (v[i]) return i;
        return 0;
    endfunction

    always @(negedge clock) begin
        logic [3:0] op, exp_op;
        logic [7:0] exp_val;
        bit [3:0]   qual, rise;
        bit         take, fault_set, popped;
        int         idx;
        if (!reset_n) begin
            check("rst_pcOpcode", bus.pcOpcode, RST);
            check("rst_pcValue", bus.pcValue, 0);
            check("rst_irqAck", bus.irqAck, 0);
            check("rst_inService", bus.inService, 0);
            check("rst_depth", bus.depth, 0);
            check("rst_stackFault", bus.stackFault, 0);
            m_mode = 0; m_stack.delete(); m_pending = 0; m_mask = 0; m_prev = 0;
            m_ack = 0; m_gen = 0; m_isr = 0; m_fault = 0;
        end else begin
            op = bus.fetchOpcode;
            take = 0; idx = 0; fault_set = 0;
            qual = m_pending & m_mask;
            if (m_mode == 1 && m_gen && !m_isr && qual != 0 && m_stack.size() < SD
                && op != RET && op != RST) begin
                take = 1;
                idx  = lowest(qual);
            end
            if (m_mode != 1) begin
                exp_op = RST; exp_val = 8'h00;
            end else if (take) begin
                exp_op = CALL; exp_val = 8'(8'h10 + 4 * idx);
            end else begin
                exp_op = op; exp_val = bus.fetchValue;
            end
            check("pcOpcode", bus.pcOpcode, exp_op);
            check("pcValue", bus.pcValue, exp_val);
            check("irqAck", bus.irqAck, m_ack);
            check("inService", bus.inService, m_isr);
            check("depth", bus.depth, m_stack.size());
            check("stackFault", bus.stackFault, m_fault);

            rise   = bus.irqReq & ~m_prev;
            m_prev = bus.irqReq;
            m_ack  = 0;
            if (m_mode == 0) begin
                m_pending |= rise;
                m_mode = 1;
            end else if (m_mode == 2) begin
                m_stack.delete(); m_isr = 0; m_pending = 0;
                m_mode = 1;
            end else begin
                if (take) begin
                    m_stack.push_back(1'b1);
                    m_isr = 1;
                    m_ack = 4'(1 << idx);
                    m_pending[idx] = 1'b0;
                end else if (op == CALL) begin
                    if (m_stack.size() == SD) begin fault_set = 1; m_mode = 2; end
                    else m_stack.push_back(1'b0);
                end else if (op == RET) begin
                    if (m_stack.size() == 0) begin fault_set = 1; m_mode = 2; end
                    else begin
                        popped = m_stack.pop_back();
                        if (popped) m_isr = 0;
                    end
                end else if (op == RST) begin
                    m_stack.delete(); m_isr = 0;
                end
                m_pending |= rise;
            end
            if (bus.cfgWrite) begin
                m_mask = bus.cfgData[3:0];
                m_gen  = bus.cfgData[4];
            end
            if (fault_set) m_fault = 1;
            else if (bus.cfgWrite && bus.cfgData[5]) m_fault = 0;
        end
    end

    task automatic tick();
        @(posedge clock); #1;
        bus.cfgWrite = 1'b0;
    endtask

    task automatic drive(input logic [3:0] op, input logic [7:0] val);
        bus.fetchOpcode = op;
        bus.fetchValue  = val;
    endtask

    task automatic cfg(input logic [5:0] data);
        bus.cfgWrite = 1'b1;
        bus.cfgData  = data;
    endtask

    initial begin
        int r, call_pct;
        drive(NOP, 8'h00);
        bus.irqReq = '0; bus.cfgWrite = 1'b0; bus.cfgData = '0;
        repeat (2) @(posedge clock);
        #1;
        @(negedge clock);
        check("lit_reset_op", bus.pcOpcode, RST);
        check("lit_reset_depth", bus.depth, 0);
        tick(); reset_n = 1'b1;

        // Reset release and passthrough
        drive(NOP, 8'h11); @(negedge clock);
        check("lit_hold_rst", bus.pcOpcode, RST);
        tick(); drive(NOP, 8'h22); @(negedge clock);
        check("lit_pass_op", bus.pcOpcode, NOP);
        check("lit_pass_val", bus.pcValue, 8'h22);
        tick(); drive(NOP, 8'h33);

        // Two simultaneous rises, lowest enabled index wins
        tick(); cfg(6'b010110); bus.irqReq = 4'b0110; drive(NOP, 8'h44);
        tick(); drive(NOP, 8'h55); @(negedge clock);
        check("lit_inj_op", bus.pcOpcode, CALL);
        check("lit_inj_vec1", bus.pcValue, 8'h14);
        tick(); @(negedge clock);
        check("lit_ack1", bus.irqAck, 4'b0010);
        check("lit_isr1", bus.inService, 1);
        check("lit_depth1", bus.depth, 1);

        // ISR return, then the other pending request is served
        tick(); drive(RET, 8'h00);
        tick(); drive(NOP, 8'h66); @(negedge clock);
        check("lit_isr_end", bus.inService, 0);
        check("lit_depth_ret", bus.depth, 0);
        check("lit_inj_vec2", bus.pcValue, 8'h18);
        tick(); drive(RET, 8'h00); @(negedge clock);
        check("lit_ack2", bus.irqAck, 4'b0100);
        tick(); drive(NOP, 8'h00); bus.irqReq = '0; cfg(6'b000000);

        // Overflow on the 17th nested CALL
        for (int i = 0; i < SD; i++) begin tick(); drive(CALL, 8'(i)); end
        tick(); drive(NOP, 8'h00); @(negedge clock);
        check("lit_full", bus.depth, 16);
        tick(); drive(CALL, 8'h77); @(negedge clock);
        check("lit_ovf_call", bus.pcOpcode, CALL);
        tick(); drive(NOP, 8'h00); @(negedge clock);
        check("lit_ovf_rst", bus.pcOpcode, RST);
        check("lit_ovf_flag", bus.stackFault, 1);
        tick(); @(negedge clock);
        check("lit_ovf_depth0", bus.depth, 0);
        tick(); @(negedge clock);
        check("lit_ovf_sticky", bus.stackFault, 1);
        tick(); cfg(6'b100000);
        tick(); @(negedge clock);
        check("lit_clear", bus.stackFault, 0);

        // Underflow with a simultaneous clear: the fault wins
        tick(); drive(RET, 8'h00); cfg(6'b100000);
        tick(); drive(NOP, 8'h00); @(negedge clock);
        check("lit_unf_flag", bus.stackFault, 1);
        check("lit_unf_rst", bus.pcOpcode, RST);
        tick(); cfg(6'b100000);

        // Request held while the stack is full
        for (int i = 0; i < SD; i++) begin tick(); drive(CALL, 8'(i)); end
        tick(); drive(NOP, 8'h00); cfg(6'b010001); bus.irqReq = 4'b0001;
        tick(); @(negedge clock);
        check("lit_full_noinj", bus.pcOpcode, NOP);
        tick(); drive(RET, 8'h00); @(negedge clock);
        check("lit_full_ret", bus.pcOpcode, RET);
        tick(); drive(NOP, 8'h00); @(negedge clock);
        check("lit_full_d15", bus.depth, 15);
        check("lit_full_vec0", bus.pcValue, 8'h10);
        tick(); @(negedge clock);
        check("lit_full_ack0", bus.irqAck, 4'b0001);

        // Reset in the middle of an ISR
        tick(); reset_n = 1'b0; @(negedge clock);
        check("lit_midisr_rst", bus.inService, 0);
        tick(); reset_n = 1'b1; bus.irqReq = '0;

        for (int c = 0; c < 3000; c++) begin
            tick();
            call_pct = (c < 1500) ? 40 : 28;
            r = $urandom_range(0, 99);
            if (r < call_pct)           drive(CALL, 8'($urandom));
            else if (r < call_pct + 30) drive(RET, 8'($urandom));
            else if (r < call_pct + 33) drive(RST, 8'($urandom));
            else if (r[0])              drive(NOP, 8'($urandom));
            else                        drive(4'($urandom_range(4, 15)), 8'($urandom));
            bus.irqReq = bus.irqReq ^ (4'($urandom) & 4'($urandom) & 4'($urandom));
            if ($urandom_range(0, 19) == 0) begin
                cfg({1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) != 0), 4'($urandom)});
            end
            reset_n = !(c >= 1500 && c < 1502);
        end

        tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
